// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART receiver: FSM states, frame width
// and the baud-divider calculation.
package bt_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: free-running 0..DIV-1 counter, realigned to the start
// edge so that sampling points sit at a fixed phase within each bit.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_clear,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || sync_clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer and
// single-cycle framing / overrun error pulses.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state_reg;
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic                 rx_prev_reg;
    logic [TW-1:0]        tick_cnt_reg;
    logic [BW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 ferr_reg;
    logic                 ovr_reg;
    logic                 start_edge;
    logic                 tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    assign start_edge = (state_reg == IDLE) && rx_prev_reg && !rx_s_reg;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clear(start_edge),
        .tick      (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
            // A load later in this block overrides the drain.
            if (valid_reg && ready_i) begin
                valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        state_reg    <= START;
                        tick_cnt_reg <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt_reg == HALF_LAST) begin
                            tick_cnt_reg <= '0;
                            bit_idx_reg  <= '0;
                            state_reg    <= rx_s_reg ? IDLE : DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg           <= '0;
                            shift_reg[bit_idx_reg] <= rx_s_reg;
                            if (bit_idx_reg == LAST_BIT) begin
                                state_reg <= STOP;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            tick_cnt_reg <= '0;
                            if (rx_s_reg) begin
                                state_reg <= IDLE;
                                if (!valid_reg || ready_i) begin
                                    data_reg  <= shift_reg;
                                    valid_reg <= 1'b1;
                                end else begin
                                    ovr_reg <= 1'b1;
                                end
                            end else begin
                                ferr_reg  <= 1'b1;
                                state_reg <= WAIT_IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_o      = data_reg;
    assign valid_o     = valid_reg;
    assign frame_err_o = ferr_reg;
    assign overrun_o   = ovr_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_bt_uart_rx.sv
// Randomised scoreboard bench for bt_uart_rx: a byte-level buffer model
// predicts accepted bytes and error pulses, a monitor pops and compares them.
module tb_bt_uart_rx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;
    // Start edge to first clk with valid_o: 9.5 bits + 2 sync + 1 output reg.
    localparam int LAT        = (BIT_CLKS * 19) / 2 + 3;

    localparam int EV_ACC  = 0;
    localparam int EV_FERR = 1;
    localparam int EV_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int   n_checks;
    int   n_pass;
    ev_t  exp_q[$];
    logic       mb_valid;
    logic [7:0] mb_data;

    bt_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, events pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Byte-level model of one received frame and the one-entry buffer.
    function automatic void model_frame(input logic [7:0] b, input logic stop_ok,
                                        input logic rdy_c, input logic rdy_after);
        if (!stop_ok) begin
            push_ev(EV_FERR, 8'h00);
            return;
        end
        if (mb_valid && !rdy_c) begin
            push_ev(EV_OVR, 8'h00);
        end else begin
            if (mb_valid) push_ev(EV_ACC, mb_data);
            mb_valid = 1'b1;
            mb_data  = b;
        end
        if (mb_valid && rdy_after) begin
            push_ev(EV_ACC, mb_data);
            mb_valid = 1'b0;
        end
    endfunction

    task automatic set_ready(input logic r);
        if (r && mb_valid) begin
            push_ev(EV_ACC, mb_data);
            mb_valid = 1'b0;
        end
        ready_i = r;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_i = stop;
        wait_clks(BIT_CLKS);
    endtask

    task automatic check_buf(input string name);
        check({name, "_valid"}, valid_o, mb_valid);
        if (mb_valid) check({name, "_data"}, data_o, mb_data);
    endtask

    task automatic observe(input int kind, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: actual kind=%0d data=%02h required none", kind, d);
            return;
        end
        e = exp_q.pop_front();
        $display("event kind=%0d data=%02h expected kind=%0d data=%02h t=%0t",
                 kind, d, e.kind, e.data, $time);
        check("event_kind", kind, e.kind);
        if (e.kind == EV_ACC && kind == EV_ACC) check("event_data", d, e.data);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (valid_o === 1'b1 && ready_i === 1'b1) observe(EV_ACC, data_o);
                if (frame_err_o === 1'b1) observe(EV_FERR, 8'h00);
                if (overrun_o === 1'b1) observe(EV_OVR, 8'h00);
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] pb;
        logic       ok;
        logic       r;

        n_checks = 0;
        n_pass   = 0;
        mb_valid = 1'b0;
        mb_data  = 8'h00;
        rst_n    = 1'b0;
        rx_i     = 1'b1;
        ready_i  = 1'b1;
        wait_clks(3);
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_ovr", overrun_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        wait_clks(20);

        // 1: single byte, exact latency
        set_ready(1'b1);
        model_frame(8'h35, 1'b1, 1'b1, 1'b1);
        fork
            send_frame(8'h35, 1'b1);
            begin
                wait_clks(LAT - 1);
                check("t1_valid_early", valid_o, 1'b0);
                wait_clks(1);
                check("t1_valid", valid_o, 1'b1);
                check("t1_data", data_o, 8'h35);
                check("t1_busy", busy_o, 1'b0);
            end
        join
        wait_clks(50);

        // 2: overrun while consumer stalls
        set_ready(1'b0);
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        check_buf("t2_hold");
        set_ready(1'b1);
        wait_clks(1);
        check("t2_valid_drop", valid_o, 1'b0);
        wait_clks(20);

        // 3: drain and load in the same cycle
        set_ready(1'b0);
        model_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1);
        wait_clks(20);
        model_frame(8'h22, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_clks(LAT - 1);
                ready_i = 1'b1;
                wait_clks(1);
                ready_i = 1'b0;
                check("t3_valid", valid_o, 1'b1);
                check("t3_data", data_o, 8'h22);
                check("t3_ovr", overrun_o, 1'b0);
            end
        join
        check_buf("t3_buf");
        set_ready(1'b1);
        wait_clks(20);

        // 4: framing error then break, then recovery
        model_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b0);
        wait_clks(3 * BIT_CLKS);
        check("t4_valid", valid_o, 1'b0);
        rx_i = 1'b1;
        wait_clks(50);
        model_frame(8'h07, 1'b1, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1);
        wait_clks(20);
        check_buf("t4_buf");

        // 5: short glitch on idle line
        rx_i = 1'b0;
        wait_clks(40);
        check("t5_busy_glitch", busy_o, 1'b1);
        rx_i = 1'b1;
        wait_clks(300);
        check("t5_busy_after", busy_o, 1'b0);
        check("t5_valid", valid_o, 1'b0);

        // 6: reset in the middle of a frame while a byte is buffered
        set_ready(1'b0);
        model_frame(8'h6B, 1'b1, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b1);
        wait_clks(20);
        check_buf("t6_pre");
        pb = 8'h55;
        rx_i = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_i = pb[i];
            wait_clks(BIT_CLKS);
        end
        rx_i = pb[4];
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        wait_clks(1);
        rst_n = 1'b1;
        rx_i  = 1'b1;
        mb_valid = 1'b0;
        check("t6_data", data_o, 8'h00);
        check("t6_valid", valid_o, 1'b0);
        check("t6_busy", busy_o, 1'b0);
        check("t6_ferr", frame_err_o, 1'b0);
        check("t6_ovr", overrun_o, 1'b0);
        wait_clks(300);
        set_ready(1'b1);
        model_frame(8'h39, 1'b1, 1'b1, 1'b1);
        send_frame(8'h39, 1'b1);
        wait_clks(20);
        check_buf("t6_post");

        // Random frames, random stop-bit validity and per-frame ready level
        for (int n = 0; n < 10; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            r  = 1'($urandom_range(0, 1));
            set_ready(r);
            model_frame(b, ok, r, r);
            send_frame(b, ok);
            rx_i = 1'b1;
            wait_clks($urandom_range(20, 200));
            check_buf("rnd_buf");
        end
        set_ready(1'b1);
        wait_clks(20);
        check_buf("final_buf");
        check("events_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bt_uart_rx.md
Name: bt_uart_rx

Overview:
UART receiver for the Bluetooth module's serial line (8N1, LSB first). It sits upstream of the seven-segment display stage inside top and delivers each received byte over a valid/ready handshake. A one-entry output buffer holds the byte until it is accepted. Framing and overrun errors are flagged with one-cycle pulses.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
(derived) DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), clocks per sample tick; must be >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
rx_i  input  1  asynchronous serial line from the Bluetooth module; idles high.
data_o  output  8  received byte; stable while valid_o=1.
valid_o  output  1  buffer holds an unconsumed byte.
ready_i  input  1  consumer accepts when valid_o && ready_i.
frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
overrun_o  output  1  one-cycle pulse: byte completed while buffer full and not being drained.
busy_o  output  1  high in any FSM state other than IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge): data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, FSM=IDLE, synchroniser FFs=1, prescaler=0, tick/bit counters=0.
- rx_i passes through a 2-FF synchroniser (rx_s); edge detection uses rx_s and its previous value.
- Prescaler: counts 0..DIV-1 and emits tick when count==DIV-1. It is forced to 0 in the cycle the start edge is detected.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a falling edge of rx_s -> START, with tick count=0.
- START: at tick count OVERSAMPLE/2-1, sample rx_s.
  - If rx_s=0 -> DATA, tick count=0, bit index=0.
  - If rx_s=1 -> IDLE (glitch rejected; no flags raised).
- DATA: each time tick count reaches OVERSAMPLE-1 (mid-bit), shift rx_s into shift[bit index] (LSB first). After bit 7 -> STOP.
- STOP: sample at tick count OVERSAMPLE-1.
  - If rx_s=1: byte complete -> IDLE.
  - If rx_s=0: frame_err_o pulses in the next cycle, the byte is discarded -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then -> IDLE. A break condition therefore produces exactly one frame_err.
- Byte-complete cycle (C), with all effects visible at C+1:
  - Buffer empty: load data_o, valid_o=1.
  - Buffer full and ready_i=1 at C: old byte consumed, new byte loaded, valid_o stays 1, no overrun.
  - Buffer full and ready_i=0 at C: new byte dropped, data_o unchanged, overrun_o pulses.
- Handshake:
  - valid_o falls the cycle after valid_o && ready_i, unless a simultaneous load occurs.
  - data_o never changes while valid_o=1 and ready_i=0.
- Latency: valid_o rises one clk after the mid-stop-bit sample. The nominal total from the start edge is about 9.5 bit periods plus 3 clks (2 for the synchroniser, 1 for the output register).
- Reset mid-frame: immediate return to the reset state. A partial byte is never delivered, and a valid_o byte is lost.
- Receiving runs independently of the output buffer; a full buffer never stalls the FSM.

Decomposition:
- Package bt_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the DATA_BITS=8 constant;
  - a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE, with round-to-nearest.
- One sub-module, uart_baud_tick: the prescaler, with inputs clk, rst_n and sync_clear, output tick, and parameter DIV.

Test Plan:
(Bench parameters: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clks. ready_i=1 unless stated.)
1. Send 0x35 ('5') as an 8N1 frame -> valid_o=1 with data_o=0x35 one clk after the mid-stop sample; no error flags; busy_o low afterwards.
2. ready_i=0; send 0xA5 then 0x3C -> data_o stays 0xA5; overrun_o pulses once at the 0x3C stop bit. Raise ready_i -> valid_o drops the next clk.
3. Buffer holds 0x11; assert ready_i exactly in the completion cycle of 0x22 -> valid_o remains 1, data_o=0x22, no overrun.
4. Send 0x5A with the stop bit driven low, then hold the line low for 3 bit times -> single frame_err_o pulse, valid_o stays 0. Line high then send 0x07 -> data_o=0x07.
5. Drive a 40-clk low glitch on an idle line -> FSM returns to IDLE; no valid_o and no flags.
6. Assert rst_n=0 for 1 clk at bit 4 of a frame -> all outputs 0 next clk. The next full frame 0x39 is received correctly.
